// File: rtl/pll_reset_sequencer.sv
// Reset sequencer for the HDMI rPLL: pulses PLL RESET, qualifies LOCK,
// then releases the downstream pixel/TMDS domain reset.
module pll_reset_sequencer #(
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 27000,
    parameter int MAX_RETRIES         = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_lock,
    input  logic       soft_restart,
    output logic       pll_reset,
    output logic       sys_rst_n,
    output logic       ready,
    output logic       fault,
    output logic [2:0] retry_count,
    output logic       lock_lost
);

    localparam int MAX_AB = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES)
                          ? PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
    localparam int MAX_C  = (MAX_AB > LOCK_TIMEOUT_CYCLES)
                          ? MAX_AB : LOCK_TIMEOUT_CYCLES;
    localparam int CW     = $clog2(MAX_C + 1);

    localparam logic [CW-1:0] RST_LAST  = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] STB_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CW-1:0] TMO_LAST  = CW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [2:0]    RETRY_MAX = 3'(MAX_RETRIES);

    localparam logic [2:0] S_PLL_RST   = 3'd0;
    localparam logic [2:0] S_WAIT_LOCK = 3'd1;
    localparam logic [2:0] S_STABLE    = 3'd2;
    localparam logic [2:0] S_RUN       = 3'd3;
    localparam logic [2:0] S_FAULT     = 3'd4;

    logic          sync1, lock_s;
    logic [2:0]    state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [2:0]    retry_d;
    logic          lost_d;

    // Two-flop synchronizer; only lock_s is used past this point
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            sync1  <= pll_lock;
            lock_s <= sync1;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        retry_d = retry_count;
        lost_d  = 1'b0;
        if (soft_restart) begin
            state_d = S_PLL_RST;
            retry_d = 3'd0;
        end else begin
            unique case (1'b1)
                (state == S_PLL_RST): begin
                    cnt_d = cnt + CW'(1);
                    if (cnt == RST_LAST)
                        state_d = S_WAIT_LOCK;
                end
                (state == S_WAIT_LOCK): begin
                    cnt_d = cnt + CW'(1);
                    if (lock_s) begin
                        state_d = S_STABLE;
                    end else if (cnt == TMO_LAST) begin
                        if (retry_count == RETRY_MAX) begin
                            state_d = S_FAULT;
                        end else begin
                            state_d = S_PLL_RST;
                            retry_d = retry_count + 3'd1;
                        end
                    end
                end
                (state == S_STABLE): begin
                    cnt_d = cnt + CW'(1);
                    if (!lock_s) begin
                        state_d = S_WAIT_LOCK;
                    end else if (cnt == STB_LAST) begin
                        state_d = S_RUN;
                        retry_d = 3'd0;
                    end
                end
                (state == S_RUN): begin
                    if (!lock_s) begin
                        state_d = S_PLL_RST;
                        lost_d  = 1'b1;
                    end
                end
                (state == S_FAULT): begin
                    state_d = S_FAULT;
                end
                default: begin
                    state_d = S_PLL_RST;
                end
            endcase
        end
        // Counter restarts on every state entry, and on any soft restart
        if (soft_restart || (state_d != state))
            cnt_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_PLL_RST;
            cnt         <= '0;
            retry_count <= 3'd0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            retry_count <= retry_d;
        end
    end

    // Outputs follow the state register one cycle later
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pll_reset <= 1'b1;
            sys_rst_n <= 1'b0;
            ready     <= 1'b0;
            fault     <= 1'b0;
            lock_lost <= 1'b0;
        end else begin
            pll_reset <= (state == S_PLL_RST) || (state == S_FAULT);
            sys_rst_n <= (state == S_RUN);
            ready     <= (state == S_RUN);
            fault     <= (state == S_FAULT);
            lock_lost <= lost_d;
        end
    end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with small timing parameters:
// nominal lock, timeouts to fault, bounce, lock loss, soft and async resets.
module tb_pll_reset_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pll_lock;
    logic       soft_restart;
    logic       pll_reset;
    logic       sys_rst_n;
    logic       ready;
    logic       fault;
    logic [2:0] retry_count;
    logic       lock_lost;

    int   total = 0;
    int   bad   = 0;
    logic seen_sys;

    pll_reset_sequencer #(
        .PLL_RST_CYCLES     (4),
        .LOCK_STABLE_CYCLES (8),
        .LOCK_TIMEOUT_CYCLES(20),
        .MAX_RETRIES        (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pll_lock    (pll_lock),
        .soft_restart(soft_restart),
        .pll_reset   (pll_reset),
        .sys_rst_n   (sys_rst_n),
        .ready       (ready),
        .fault       (fault),
        .retry_count (retry_count),
        .lock_lost   (lock_lost)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (sys_rst_n !== 1'b0) seen_sys = 1'b1;
        end
    endtask

    // Reset pulse placed between edges; the next posedge is edge 1
    task automatic restart(input logic lk);
        @(posedge clk);
        #1;
        rst_n    = 1'b0;
        pll_lock = lk;
        #2;
        rst_n    = 1'b1;
    endtask

    initial begin
        rst_n        = 1'b1;
        pll_lock     = 1'b1;
        soft_restart = 1'b0;
        seen_sys     = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_pll_reset", 32'(pll_reset), 32'd1);
        chk("rst_sys_rst_n", 32'(sys_rst_n), 32'd0);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_retry", 32'(retry_count), 32'd0);
        chk("rst_lock_lost", 32'(lock_lost), 32'd0);

        // Nominal: lock present from the start
        restart(1'b1);
        ticks(4);
        chk("s1_pllrst_e4", 32'(pll_reset), 32'd1);
        ticks(1);
        chk("s1_pllrst_e5", 32'(pll_reset), 32'd0);
        ticks(8);
        chk("s1_ready_e13", 32'(ready), 32'd0);
        chk("s1_sys_e13", 32'(sys_rst_n), 32'd0);
        ticks(1);
        chk("s1_ready_e14", 32'(ready), 32'd1);
        chk("s1_sys_e14", 32'(sys_rst_n), 32'd1);
        chk("s1_retry", 32'(retry_count), 32'd0);
        chk("s1_pllrst_run", 32'(pll_reset), 32'd0);

        // Lock loss in RUN for 3 cycles
        ticks(2);
        pll_lock = 1'b0;
        ticks(2);
        chk("s4_lost_b", 32'(lock_lost), 32'd0);
        chk("s4_ready_b", 32'(ready), 32'd1);
        ticks(1);
        chk("s4_lost_c", 32'(lock_lost), 32'd1);
        chk("s4_sys_c", 32'(sys_rst_n), 32'd1);
        pll_lock = 1'b1;
        ticks(1);
        chk("s4_lost_d", 32'(lock_lost), 32'd0);
        chk("s4_sys_d", 32'(sys_rst_n), 32'd0);
        chk("s4_ready_d", 32'(ready), 32'd0);
        chk("s4_pllrst_d", 32'(pll_reset), 32'd1);
        ticks(3);
        chk("s4_pllrst_c4", 32'(pll_reset), 32'd1);
        ticks(1);
        chk("s4_pllrst_c5", 32'(pll_reset), 32'd0);
        ticks(8);
        chk("s4_ready_c13", 32'(ready), 32'd0);
        ticks(1);
        chk("s4_ready_c14", 32'(ready), 32'd1);
        chk("s4_retry", 32'(retry_count), 32'd0);
        chk("s4_lost_end", 32'(lock_lost), 32'd0);

        // Asynchronous reset mid-RUN
        #2 rst_n = 1'b0;
        #1;
        chk("s6r_sys", 32'(sys_rst_n), 32'd0);
        chk("s6r_ready", 32'(ready), 32'd0);
        chk("s6r_pllrst", 32'(pll_reset), 32'd1);
        chk("s6r_fault", 32'(fault), 32'd0);

        // Lock bounce during STABLE
        restart(1'b0);
        ticks(4);
        pll_lock = 1'b1;
        ticks(5);
        pll_lock = 1'b0;
        ticks(1);
        pll_lock = 1'b1;
        ticks(3);
        chk("s3_pllrst_e13", 32'(pll_reset), 32'd0);
        chk("s3_retry_e13", 32'(retry_count), 32'd0);
        ticks(7);
        chk("s3_ready_e20", 32'(ready), 32'd0);
        ticks(1);
        chk("s3_ready_e21", 32'(ready), 32'd0);
        ticks(1);
        chk("s3_ready_e22", 32'(ready), 32'd1);
        chk("s3_retry_e22", 32'(retry_count), 32'd0);

        // Lock stuck low: three attempts then FAULT
        restart(1'b0);
        seen_sys = 1'b0;
        ticks(5);
        chk("s2_pllrst_e5", 32'(pll_reset), 32'd0);
        ticks(18);
        chk("s2_retry_e23", 32'(retry_count), 32'd0);
        ticks(1);
        chk("s2_retry_e24", 32'(retry_count), 32'd1);
        ticks(1);
        chk("s2_pllrst_e25", 32'(pll_reset), 32'd1);
        ticks(22);
        chk("s2_retry_e47", 32'(retry_count), 32'd1);
        ticks(1);
        chk("s2_retry_e48", 32'(retry_count), 32'd2);
        ticks(24);
        chk("s2_fault_e72", 32'(fault), 32'd0);
        chk("s2_pllrst_e72", 32'(pll_reset), 32'd0);
        ticks(1);
        chk("s2_fault_e73", 32'(fault), 32'd1);
        chk("s2_pllrst_e73", 32'(pll_reset), 32'd1);
        chk("s2_retry_e73", 32'(retry_count), 32'd2);
        ticks(50);
        chk("s2_fault_hold", 32'(fault), 32'd1);
        chk("s2_pllrst_hold", 32'(pll_reset), 32'd1);
        chk("s2_retry_hold", 32'(retry_count), 32'd2);
        chk("s2_sys_never", 32'(seen_sys), 32'd0);

        // Soft restart out of FAULT with lock present
        pll_lock = 1'b1;
        ticks(3);
        soft_restart = 1'b1;
        ticks(1);
        soft_restart = 1'b0;
        chk("s5_fault_s", 32'(fault), 32'd1);
        chk("s5_retry_s", 32'(retry_count), 32'd0);
        ticks(1);
        chk("s5_fault_s1", 32'(fault), 32'd0);
        chk("s5_pllrst_s1", 32'(pll_reset), 32'd1);
        ticks(3);
        chk("s5_pllrst_s4", 32'(pll_reset), 32'd1);
        ticks(1);
        chk("s5_pllrst_s5", 32'(pll_reset), 32'd0);
        ticks(8);
        chk("s5_ready_s13", 32'(ready), 32'd0);
        ticks(1);
        chk("s5_ready_s14", 32'(ready), 32'd1);
        chk("s5_fault_run", 32'(fault), 32'd0);

        // Soft restart in RUN: no lock_lost pulse
        ticks(2);
        soft_restart = 1'b1;
        ticks(1);
        soft_restart = 1'b0;
        chk("sr_ready_s", 32'(ready), 32'd1);
        chk("sr_lost_s", 32'(lock_lost), 32'd0);
        ticks(1);
        chk("sr_ready_s1", 32'(ready), 32'd0);
        chk("sr_sys_s1", 32'(sys_rst_n), 32'd0);
        chk("sr_lost_s1", 32'(lock_lost), 32'd0);
        chk("sr_pllrst_s1", 32'(pll_reset), 32'd1);
        ticks(12);
        chk("sr_ready_s13", 32'(ready), 32'd0);
        ticks(1);
        chk("sr_ready_s14", 32'(ready), 32'd1);

        // Asynchronous reset mid-STABLE
        restart(1'b1);
        ticks(8);
        chk("s6s_pllrst_pre", 32'(pll_reset), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("s6s_pllrst", 32'(pll_reset), 32'd1);
        chk("s6s_sys", 32'(sys_rst_n), 32'd0);
        chk("s6s_retry", 32'(retry_count), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
